// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// NOP encoding and register-index width.
package hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // True when a load in EX produces a register the ID instruction consumes.
    function automatic logic load_use_hit(
        input logic                 ex_mem_read,
        input logic [REG_IDX_W-1:0] ex_rd,
        input logic [REG_IDX_W-1:0] id_rs1,
        input logic [REG_IDX_W-1:0] id_rs2,
        input logic                 id_use_rs1,
        input logic                 id_use_rs2
    );
        return ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_perf.sv
// Saturating stall/flush event counters for the hazard controller
// (present only in builds with HAZARD_CTRL_PERF_EN).
module hazard_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_inc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: stage enables/flushes, dmem wait
// tracking with timeout; HAZARD_CTRL_PERF_EN adds stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_redirect,
    input  logic                 mem_access,
    input  logic                 dmem_ready,
    input  logic                 imem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_flush,
    output logic                 err
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
`endif
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              dmem_stall;
    logic              load_use;

    assign dmem_stall = mem_access && !dmem_ready;
    assign load_use   = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_stall) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // A redirect held across a dmem stall is simply re-seen on the ready
    // cycle, since EX is frozen; nothing is stored.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        err          = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state_q == ST_ERROR) begin
            err = 1'b1;
        end else if (dmem_stall) begin
            mem_wb_en    = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !rst && (state_q != ST_ERROR) &&
                       !(pc_en && if_id_en && id_ex_en && ex_mem_en && mem_wb_en);
    assign flush_inc = !rst && (if_id_flush || id_ex_flush || mem_wb_flush);

    hazard_ctrl_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_inc   (stall_inc),
        .flush_inc   (flush_inc),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expected outputs per cycle,
// monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush, err}
    localparam logic [8:0] E_RESET = 9'b00000_111_0;
    localparam logic [8:0] E_NORM  = 9'b11111_000_0;
    localparam logic [8:0] E_DMEM  = 9'b00001_001_0;
    localparam logic [8:0] E_REDIR = 9'b11111_110_0;
    localparam logic [8:0] E_LU    = 9'b00111_010_0;
    localparam logic [8:0] E_IMEM  = 9'b01111_100_0;
    localparam logic [8:0] E_ERR   = 9'b00000_000_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic       mem_access, dmem_ready, imem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, err;
`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

    typedef struct {
        logic [8:0] outs;
        string      nm;
        bit         chk_perf;
        int         s;
        int         f;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_redirect (ex_redirect),
        .mem_access  (mem_access),
        .dmem_ready  (dmem_ready),
        .imem_ready  (imem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .mem_wb_flush(mem_wb_flush),
        .err         (err)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    initial begin
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_flush, err};
                total++;
                if (act !== e.outs) begin
                    bad++;
                    $display("FAIL %s: got %b want %b", e.nm, act, e.outs);
                end
`ifdef HAZARD_CTRL_PERF_EN
                if (e.chk_perf) begin
                    total++;
                    if (stall_cycles !== CNT_W'(e.s) || flush_events !== CNT_W'(e.f)) begin
                        bad++;
                        $display("FAIL %s_cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                                 e.nm, stall_cycles, flush_events, e.s, e.f);
                    end
                end
`endif
            end
        end
    end

    task automatic cycp(input logic [8:0] ex, input string nm, input bit cp, input int s, input int f);
        exp_t e;
        e.outs = ex; e.nm = nm; e.chk_perf = cp; e.s = s; e.f = f;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [8:0] ex, input string nm);
        cycp(ex, nm, 1'b0, 0, 0);
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        cyc(E_RESET, "reset0");
        cyc(E_RESET, "reset1");

        // imem stalls straight out of reset; narrow counters saturate at 15
        rst = 1'b0;
        imem_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            n = (i > 15) ? 15 : i;
            cycp(E_IMEM, (i == 10) ? "perf10" : "imem_stall", 1'b1, n, n);
        end
        idle();
        cyc(E_NORM, "idle");

        // load-use on rs1, one cycle only
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cyc(E_LU, "load_use_rs1");
        idle();
        cyc(E_NORM, "after_load_use");

        // x0 destination never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cyc(E_NORM, "x0_load");

        // rs2 match, and an rs1 match that the instruction does not use
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
        cyc(E_LU, "load_use_rs2");
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
        cyc(E_NORM, "rs1_unused");
        ex_mem_read = 1'b0; id_use_rs1 = 1'b1;
        cyc(E_NORM, "not_a_load");

        // redirect beats load-use and imem stall
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
        cyc(E_REDIR, "redirect_lu");
        idle();
        ex_redirect = 1'b1; imem_ready = 1'b0;
        cyc(E_REDIR, "redirect_imem");
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1; imem_ready = 1'b0;
        cyc(E_LU, "lu_over_imem");

        // redirect held across 3 dmem-stall cycles, acted on when ready
        idle();
        mem_access = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
        for (int i = 0; i < 3; i++) cyc(E_DMEM, "dmem_stall_redirect");
        dmem_ready = 1'b1;
        cyc(E_REDIR, "dmem_ready_redirect");
        idle();
        cyc(E_NORM, "back_to_run");

        // 4 waits then ready: counter must restart, so no timeout
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(E_DMEM, "dmem_wait4");
        dmem_ready = 1'b1;
        cyc(E_NORM, "dmem_done4");
        idle();
        cyc(E_NORM, "no_timeout");

        // reset mid-MEM_WAIT discards the pending redirect
        mem_access = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
        cyc(E_DMEM, "pre_rst_wait0");
        cyc(E_DMEM, "pre_rst_wait1");
        rst = 1'b1;
        cyc(E_RESET, "rst_mid_wait");
        rst = 1'b0;
        idle();
        cyc(E_NORM, "after_rst_wait");

        // timeout: ERROR after the 5th edge with dmem never ready
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc(E_DMEM, "timeout_wait");
        cyc(E_ERR, "error_state");
        idle();
        ex_redirect = 1'b1;
        cyc(E_ERR, "error_sticky");
        cyc(E_ERR, "error_sticky2");
        rst = 1'b1;
        cyc(E_RESET, "rst_in_error");
        rst = 1'b0;
        idle();
        cyc(E_NORM, "after_error_rst");
        imem_ready = 1'b0;
        cyc(E_IMEM, "final_imem");
        idle();

        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, consecutive dmem-not-ready cycles tolerated before error (range 2..65535).
REQ-002 Parameter: CNT_W, default 32, width of performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_mem_read  in  1  EX instruction is a load.
REQ-009 ex_redirect  in  1  branch taken, jal or jalr resolved in EX.
REQ-010 mem_access  in  1  MEM-stage instruction is a load or store.
REQ-011 dmem_ready  in  1  data memory completes the access this cycle.
REQ-012 imem_ready  in  1  instruction memory returns a valid fetch this cycle.
REQ-013 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register update enables.
REQ-014 if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP) into that stage register.
REQ-015 err  out  1  sticky dmem timeout error.

Function
REQ-016 States: RUN, MEM_WAIT, ERROR; state register only, all enable/flush outputs combinational from state and inputs.
REQ-017 dmem stall (mem_access & !dmem_ready, state RUN or MEM_WAIT), highest priority: pc/if_id/id_ex/ex_mem enables 0, mem_wb_en 1, mem_wb_flush 1, no other flush.
REQ-018 Redirect (ex_redirect, no dmem stall): all enables 1, if_id_flush 1, id_ex_flush 1; load-use and imem stall ignored that cycle.
REQ-019 Load-use (ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)), no dmem stall, no redirect): pc_en 0, if_id_en 0, id_ex_flush 1, others enabled; lasts exactly the cycles the condition holds.
REQ-020 imem stall (!imem_ready, none of the above): pc_en 0, if_id_flush 1, downstream enabled.
REQ-021 No hazard: all enables 1, all flushes 0.
REQ-022 Redirect held during dmem stall is acted on in the first cycle dmem_ready is high; no flush issued while stalled.
REQ-023 RUN -> MEM_WAIT when mem_access & !dmem_ready; wait counter loaded with 1.
REQ-024 MEM_WAIT -> RUN when dmem_ready; else if wait counter == TIMEOUT -> ERROR; else counter increments.
REQ-025 ERROR: all enables 0, all flushes 0, err 1; exit only by rst.
REQ-026 Wait counter width ceil(log2(TIMEOUT+1)); never wraps.

Reset
REQ-027 While rst high: all enables 0, all flushes 1, err 0.
REQ-028 After rst edge: state RUN, wait counter 0, err 0, performance counters 0.
REQ-029 rst mid-MEM_WAIT or in ERROR returns to RUN at that edge; no pending redirect retained.

Configuration
REQ-030 Macro HAZARD_CTRL_PERF_EN defined: outputs stall_cycles and flush_events (CNT_W each) exist; stall_cycles +1 per cycle any *_en is 0 outside reset/ERROR; flush_events +1 per cycle any flush is 1 outside reset; both saturate at all-ones.
REQ-031 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-032 Shared package: state encoding (RUN=0, MEM_WAIT=1, ERROR=2, 2 bits), NOP encoding 32'h0000_0013, register-index width 5.
REQ-033 One sub-module: hazard_ctrl_perf (the saturating counters), instantiated only under HAZARD_CTRL_PERF_EN.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only; next cycle all clear.
REQ-035 x0 load: same as REQ-034 with ex_rd=0 -> no stall.
REQ-036 Redirect + load-use same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_en=1.
REQ-037 mem_access=1, dmem_ready=0 for 3 cycles with ex_redirect=1 -> 3 cycles upstream enables 0, mem_wb_flush=1; cycle 4 (ready) flushes IF/ID and ID/EX; state back to RUN.
REQ-038 TIMEOUT=4, dmem_ready held 0 -> state ERROR after 5th edge, err=1, all enables 0; rst 1 cycle -> RUN, err=0.
REQ-039 PERF_EN build: 10 imem-stall cycles from reset -> stall_cycles=10, flush_events=10; preset near all-ones -> saturates, no wrap.
